pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//   Central stall/flush sequencer for the 5-stage pipeline. Combines the load-use stall from
//   forwarding, I/D-cache stalls, ID-stage branch redirects and halt into per-stage
//   write-enable/flush controls. Runs a BOOT->RUN->DRAIN->HALT sequence and keeps saturating
//   performance counters. Sits beside forwarding; drives PC, IF/ID, ID/EX, EX/ME and ME/WB.
// PARAMETERS
//   BOOT_CYC   2   cycles after reset with pipeline held and bubbled (>=1)
//   DRAIN_CYC  4   non-frozen cycles to retire in-flight instructions after halt (>=1)
//   CNT_W      32  width of each performance counter
// PORTS
//   clk             in   1      clock, rising edge
//   rst             in   1      synchronous reset, active-high
//   forward_stall_i in   1      load-use/ID-operand hazard from forwarding
//   icache_stall_i  in   1      I-cache miss in progress
//   dcache_stall_i  in   1      D-cache miss in progress
//   branch_flush_i  in   1      ID-stage branch/jump taken; PC loads target
//   halt_i          in   1      halt instruction decoded in ID
//   PC_we_o         out  1      PC register write enable
//   IF_ID_we_o      out  1      IF/ID write enable
//   IF_ID_flush_o   out  1      load NOP into IF/ID (valid only with IF_ID_we_o=1)
//   ID_EX_we_o      out  1      ID/EX write enable
//   ID_EX_bubble_o  out  1      load NOP into ID/EX instead of ID result
//   EX_ME_we_o      out  1      EX/ME write enable
//   ME_WB_we_o      out  1      ME/WB write enable
//   done_o          out  1      1 while state==HALT
//   cyc_cnt_o       out  CNT_W  cycles spent in RUN+DRAIN
//   stall_cnt_o     out  CNT_W  RUN/DRAIN cycles with freeze or RUN hazard
//   flush_cnt_o     out  CNT_W  RUN cycles with branch flush applied
// BEHAVIOUR
//   - Registered: state, drain counter, three perf counters. Enables/flushes combinational.
//   - freeze = icache_stall_i | dcache_stall_i. Priority: freeze > hazard > flush > halt.
//   - Reset: state=BOOT, boot_cnt=0, counters=0, done_o=0. rst wins over everything,
//     including freeze and mid-DRAIN.
//   - BOOT: all *_we_o=1, IF_ID_flush_o=1, ID_EX_bubble_o=1, PC_we_o=0.
//     Leave to RUN after BOOT_CYC cycles, ignoring freeze.
//   - RUN, freeze: all *_we_o=0, flush/bubble=0. Branch and halt are ignored;
//     ID is held, so they reappear.
//   - RUN, hazard (forward_stall_i & ~freeze): PC_we_o=0, IF_ID_we_o=0, ID_EX_we_o=1,
//     ID_EX_bubble_o=1, EX_ME_we_o=ME_WB_we_o=1.
//     branch_flush_i/halt_i ignored (operands not ready).
//   - RUN, flush (branch_flush_i, no freeze/hazard): all we=1, IF_ID_flush_o=1.
//     halt_i the same cycle is ignored.
//   - RUN, halt (halt_i only): all we=1, PC_we_o=0. Next state DRAIN; drain_cnt=DRAIN_CYC.
//   - RUN, otherwise: all we=1, flush/bubble=0.
//   - DRAIN: PC_we_o=0, IF_ID_flush_o=1, other we=1. forward_stall_i/branch_flush_i/halt_i
//     ignored. Freeze zeroes all we and holds drain_cnt.
//     Each non-frozen cycle decrements; drain_cnt==1 & ~freeze -> HALT.
//   - HALT: all we=0, flush/bubble=0, done_o=1 until rst.
//   - Counters saturate at all-ones, never wrap; frozen in BOOT and HALT.
//   - Any output reaching the register file/memory while a stage is bubbled is the
//     stage's concern; this block guarantees only the enables above.
// TESTING
//   1. rst 1->0, BOOT_CYC=2 -> cycles 0-1 PC_we_o=0, IF_ID_flush_o=1, ID_EX_bubble_o=1;
//      cycle 2 all we=1, no flush.
//   2. RUN, forward_stall_i=1 & branch_flush_i=1 one cycle, then branch_flush_i alone ->
//      cycle A: PC_we_o=0, IF_ID_we_o=0, ID_EX_bubble_o=1, IF_ID_flush_o=0;
//      cycle B: IF_ID_flush_o=1; flush_cnt_o=1, stall_cnt_o=1.
//   3. dcache_stall_i=1 for 3 cycles overlapping forward_stall_i=1 -> all we=0 for 3 cycles,
//      then hazard response; stall_cnt_o increases by 4.
//   4. halt_i at cycle t, DRAIN_CYC=4, icache_stall_i at t+2..t+3 ->
//      PC_we_o=0 from t; done_o=1 first at t+7.
//   5. rst=1 during DRAIN while dcache_stall_i=1 -> next cycle state BOOT, counters 0,
//      done_o=0, BOOT outputs.
//   6. CNT_W=4, 20 free RUN cycles -> cyc_cnt_o saturates at 15, no wrap.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard/cache/branch/halt inputs and per-stage enable/flush outputs of pipeline_ctrl.
interface pipeline_ctrl_if #(parameter int CNT_W = 32);
  logic forward_stall_i;
  logic icache_stall_i;
  logic dcache_stall_i;
  logic branch_flush_i;
  logic halt_i;
  logic PC_we_o;
  logic IF_ID_we_o;
  logic IF_ID_flush_o;
  logic ID_EX_we_o;
  logic ID_EX_bubble_o;
  logic EX_ME_we_o;
  logic ME_WB_we_o;
  logic done_o;
  logic [CNT_W-1:0] cyc_cnt_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  modport master (
    output forward_stall_i, icache_stall_i, dcache_stall_i, branch_flush_i, halt_i,
    input  PC_we_o, IF_ID_we_o, IF_ID_flush_o, ID_EX_we_o, ID_EX_bubble_o, EX_ME_we_o,
    input  ME_WB_we_o, done_o, cyc_cnt_o, stall_cnt_o, flush_cnt_o
  );
  modport slave (
    input  forward_stall_i, icache_stall_i, dcache_stall_i, branch_flush_i, halt_i,
    output PC_we_o, IF_ID_we_o, IF_ID_flush_o, ID_EX_we_o, ID_EX_bubble_o, EX_ME_we_o,
    output ME_WB_we_o, done_o, cyc_cnt_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer (BOOT->RUN->DRAIN->HALT) with saturating perf counters.
module pipeline_ctrl #(
  parameter int BOOT_CYC  = 2,
  parameter int DRAIN_CYC = 4,
  parameter int CNT_W     = 32
) (
  input logic clk,
  input logic rst,
  pipeline_ctrl_if.slave bus
);
  localparam int MAXC = (BOOT_CYC > DRAIN_CYC) ? BOOT_CYC : DRAIN_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALT} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cyc_q, stall_q, flush_q;
  logic freeze, hazard, flush, halt_go, active, stall_ev, flush_ev;
  logic pc_we, ifid_we, ifid_fl, idex_we, bub, exme_we, mewb_we;
  assign freeze   = bus.icache_stall_i | bus.dcache_stall_i;
  assign hazard   = bus.forward_stall_i & ~freeze;
  assign flush    = bus.branch_flush_i & ~freeze & ~bus.forward_stall_i;
  assign halt_go  = bus.halt_i & ~freeze & ~bus.forward_stall_i & ~bus.branch_flush_i;
  assign active   = (state_q == RUN) || (state_q == DRAIN);
  assign stall_ev = active & (freeze | ((state_q == RUN) & hazard));
  assign flush_ev = (state_q == RUN) & flush;
  // cnt_q counts boot cycles up in BOOT and remaining drain cycles down in DRAIN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_we   = 1'b0;
    ifid_we = 1'b0;
    ifid_fl = 1'b0;
    idex_we = 1'b0;
    bub     = 1'b0;
    exme_we = 1'b0;
    mewb_we = 1'b0;
    case (state_q)
      BOOT: begin
        {ifid_we, ifid_fl, idex_we, bub, exme_we, mewb_we} = '1;
        cnt_d   = (cnt_q == CW'(BOOT_CYC - 1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == CW'(BOOT_CYC - 1)) ? RUN : BOOT;
      end
      RUN: if (!freeze) begin
        {idex_we, exme_we, mewb_we} = '1;
        ifid_we = ~hazard;
        bub     = hazard;
        ifid_fl = flush;
        pc_we   = ~hazard & ~halt_go;
        state_d = halt_go ? DRAIN : RUN;
        cnt_d   = halt_go ? CW'(DRAIN_CYC) : cnt_q;
      end
      DRAIN: if (!freeze) begin
        {ifid_we, ifid_fl, idex_we, exme_we, mewb_we} = '1;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CW'(1)) ? HALT : DRAIN;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      cnt_q   <= '0;
      cyc_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= (active & ~&cyc_q) ? cyc_q + 1'b1 : cyc_q;
      stall_q <= (stall_ev & ~&stall_q) ? stall_q + 1'b1 : stall_q;
      flush_q <= (flush_ev & ~&flush_q) ? flush_q + 1'b1 : flush_q;
    end
  end
  assign bus.PC_we_o        = pc_we;
  assign bus.IF_ID_we_o     = ifid_we;
  assign bus.IF_ID_flush_o  = ifid_fl;
  assign bus.ID_EX_we_o     = idex_we;
  assign bus.ID_EX_bubble_o = bub;
  assign bus.EX_ME_we_o     = exme_we;
  assign bus.ME_WB_we_o     = mewb_we;
  assign bus.done_o         = (state_q == HALT);
  assign bus.cyc_cnt_o      = cyc_q;
  assign bus.stall_cnt_o    = stall_q;
  assign bus.flush_cnt_o    = flush_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed stimulus against a behavioural model plus literal pins, on a 32-bit and a 4-bit counter instance.
module tb_pipeline_ctrl;
  localparam int BOOT_CYC  = 2;
  localparam int DRAIN_CYC = 4;
  // {PC_we, IF_ID_we, IF_ID_flush, ID_EX_we, ID_EX_bubble, EX_ME_we, ME_WB_we, done}
  localparam logic [7:0] V_BOOT  = 8'b0111_1110;
  localparam logic [7:0] V_RUN   = 8'b1101_0110;
  localparam logic [7:0] V_HAZ   = 8'b0001_1110;
  localparam logic [7:0] V_FL    = 8'b1111_0110;
  localparam logic [7:0] V_HLT   = 8'b0101_0110;
  localparam logic [7:0] V_DRAIN = 8'b0111_0110;
  localparam logic [7:0] V_FRZ   = 8'b0000_0000;
  localparam logic [7:0] V_HALT  = 8'b0000_0001;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fs = 1'b0, ic = 1'b0, dc = 1'b0, br = 1'b0, ht = 1'b0;
  always #5 clk = ~clk;
  pipeline_ctrl_if #(.CNT_W(32)) b32 ();
  pipeline_ctrl_if #(.CNT_W(4))  b4 ();
  pipeline_ctrl #(.BOOT_CYC(BOOT_CYC), .DRAIN_CYC(DRAIN_CYC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(b32.slave));
  pipeline_ctrl #(.BOOT_CYC(BOOT_CYC), .DRAIN_CYC(DRAIN_CYC), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(b4.slave));
  assign {b32.forward_stall_i, b32.icache_stall_i, b32.dcache_stall_i, b32.branch_flush_i, b32.halt_i} = {fs, ic, dc, br, ht};
  assign {b4.forward_stall_i, b4.icache_stall_i, b4.dcache_stall_i, b4.branch_flush_i, b4.halt_i} = {fs, ic, dc, br, ht};
  logic [7:0] o32, o4;
  assign o32 = {b32.PC_we_o, b32.IF_ID_we_o, b32.IF_ID_flush_o, b32.ID_EX_we_o,
                b32.ID_EX_bubble_o, b32.EX_ME_we_o, b32.ME_WB_we_o, b32.done_o};
  assign o4  = {b4.PC_we_o, b4.IF_ID_we_o, b4.IF_ID_flush_o, b4.ID_EX_we_o,
                b4.ID_EX_bubble_o, b4.EX_ME_we_o, b4.ME_WB_we_o, b4.done_o};
  // literal expectations for the current cycle, written only by the stimulus process
  logic       l_on = 1'b0;
  logic [7:0] l_val = '0;
  string      l_name = "";
  int l_cyc = -1, l_stall = -1, l_flush = -1, l_cyc4 = -1;
  int checks = 0, failures = 0;
  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", n, act, exp, $time);
    end
  endtask
  // model: mode 0 BOOT, 1 RUN, 2 DRAIN, 3 HALT; counters kept unbounded
  int m_mode = 0, m_boot_left = 0, m_drain_left = 0;
  longint m_cyc = 0, m_stall = 0, m_flush = 0;
  bit m_valid = 1'b0;
  function automatic longint sat4(input longint x);
    return (x > 15) ? 15 : x;
  endfunction
  always @(negedge clk) begin : cmp
    logic frz;
    logic [7:0] e;
    frz = ic | dc;
    if (m_valid) begin
      e = (m_mode == 0) ? V_BOOT : (m_mode == 3) ? V_HALT : frz ? V_FRZ :
          (m_mode == 2) ? V_DRAIN : fs ? V_HAZ : br ? V_FL : ht ? V_HLT : V_RUN;
      check("ctl32", {56'd0, o32}, {56'd0, e});
      check("ctl4", {56'd0, o4}, {56'd0, e});
      check("cyc32", {32'd0, b32.cyc_cnt_o}, m_cyc);
      check("stall32", {32'd0, b32.stall_cnt_o}, m_stall);
      check("flush32", {32'd0, b32.flush_cnt_o}, m_flush);
      check("cyc4", {60'd0, b4.cyc_cnt_o}, sat4(m_cyc));
      check("stall4", {60'd0, b4.stall_cnt_o}, sat4(m_stall));
      check("flush4", {60'd0, b4.flush_cnt_o}, sat4(m_flush));
    end
    if (l_on) check(l_name, {56'd0, o32}, {56'd0, l_val});
    if (l_cyc >= 0) check("lit_cyc", {32'd0, b32.cyc_cnt_o}, 64'(l_cyc));
    if (l_stall >= 0) check("lit_stall", {32'd0, b32.stall_cnt_o}, 64'(l_stall));
    if (l_flush >= 0) check("lit_flush", {32'd0, b32.flush_cnt_o}, 64'(l_flush));
    if (l_cyc4 >= 0) check("lit_cyc4", {60'd0, b4.cyc_cnt_o}, 64'(l_cyc4));
    if (rst) begin
      m_mode = 0; m_boot_left = BOOT_CYC; m_drain_left = 0;
      m_cyc = 0; m_stall = 0; m_flush = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_mode == 1 || m_mode == 2) begin
        m_cyc++;
        if (frz || (m_mode == 1 && fs)) m_stall++;
        if (m_mode == 1 && !frz && !fs && br) m_flush++;
      end
      if (m_mode == 0) begin
        m_boot_left--;
        if (m_boot_left == 0) m_mode = 1;
      end else if (m_mode == 1) begin
        if (!frz && !fs && !br && ht) begin m_mode = 2; m_drain_left = DRAIN_CYC; end
      end else if (m_mode == 2 && !frz) begin
        m_drain_left--;
        if (m_drain_left == 0) m_mode = 3;
      end
    end
  end
  task automatic drive(input logic f, i, d, b, h, input logic [7:0] v, input string n);
    {fs, ic, dc, br, ht} = {f, i, d, b, h};
    l_on = (n != ""); l_val = v; l_name = n;
    l_cyc = -1; l_stall = -1; l_flush = -1; l_cyc4 = -1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, V_BOOT, "boot_c0"); l_cyc = 0; tick();
    drive(0, 1, 0, 0, 0, V_BOOT, "boot_c1_frz"); tick();
    drive(0, 0, 0, 0, 0, V_RUN, "run_c2"); l_cyc = 0; tick();
    drive(1, 0, 0, 1, 0, V_HAZ, "hazard_over_branch"); tick();
    drive(0, 0, 0, 1, 0, V_FL, "branch_flush"); tick();
    drive(0, 0, 0, 0, 0, V_RUN, "run_after_flush"); l_cyc = 3; l_stall = 1; l_flush = 1; tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 1, 0, 0, V_FRZ, "dcache_freeze"); tick();
    end
    drive(1, 0, 0, 0, 0, V_HAZ, "hazard_after_freeze"); tick();
    drive(0, 0, 0, 0, 0, V_RUN, "run_after_hazard"); l_cyc = 8; l_stall = 5; l_flush = 1; tick();
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 0, 0, 0, V_RUN, ""); tick();
    end
    drive(0, 0, 0, 0, 0, V_RUN, "run_free"); l_cyc = 29; l_cyc4 = 15; tick();
    drive(0, 0, 0, 0, 1, V_HLT, "halt_t"); tick();
    drive(0, 0, 0, 0, 0, V_DRAIN, "drain_t1"); tick();
    drive(0, 1, 0, 0, 0, V_FRZ, "drain_frz_t2"); tick();
    drive(0, 1, 0, 0, 0, V_FRZ, "drain_frz_t3"); tick();
    drive(0, 0, 0, 0, 0, V_DRAIN, "drain_t4"); tick();
    drive(0, 0, 0, 0, 0, V_DRAIN, "drain_t5"); tick();
    drive(1, 0, 0, 1, 1, V_DRAIN, "drain_t6_ignores"); tick();
    drive(0, 0, 0, 0, 0, V_HALT, "halt_t7"); l_cyc = 37; l_stall = 7; l_flush = 1; tick();
    drive(1, 1, 0, 1, 1, V_HALT, "halt_hold"); l_cyc = 37; tick();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, V_HALT, "halt_before_rst"); tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, V_BOOT, "reboot_c0"); tick();
    drive(0, 0, 0, 0, 0, V_BOOT, "reboot_c1"); tick();
    drive(0, 0, 0, 0, 0, V_RUN, "rerun"); tick();
    drive(0, 0, 0, 0, 1, V_HLT, "rehalt"); tick();
    rst = 1'b1;
    drive(0, 0, 1, 0, 0, V_FRZ, "drain_frz_rst"); tick();
    rst = 1'b0;
    drive(0, 0, 1, 0, 0, V_BOOT, "boot_after_rst"); l_cyc = 0; l_stall = 0; l_flush = 0; l_cyc4 = 0; tick();
    drive(0, 0, 0, 0, 0, V_BOOT, "boot_after_rst_c1"); tick();
    drive(0, 0, 0, 0, 0, V_RUN, "run_after_rst"); l_cyc = 0; tick();
    drive(0, 0, 0, 0, 0, V_RUN, ""); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
